// File: rtl/column_sum_normalizer_78.sv
// Carry-resolving back end of the column-sum adder: takes three overlapping
// 2*radix-bit partial sums and streams the exact total as radix-bit digits, LSB first.
module column_sum_normalizer_78 #(
    parameter int radix   = 78,
    parameter int NUM_DIG = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*radix-1:0]   res_0,
    input  logic [2*radix-1:0]   res_1,
    input  logic [2*radix-1:0]   res_2,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [radix-1:0]     dig_out,
    output logic [2:0]           dig_idx,
    output logic                 dig_last,
    output logic                 busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIG - 1);

    logic [0:0]           state;
    logic [2*radix-1:0]   r0, r1, r2;
    logic [1:0]           carry;
    logic [radix+1:0]     s;
    logic                 accept;
    logic                 fire;

    assign accept = in_valid & in_ready & (state == IDLE);
    assign fire   = dig_valid & dig_ready;
    assign busy   = (state == EMIT);

    // Next digit is formed from whatever lands in the column above the current index.
    always_comb begin
        s = '0;
        case (dig_idx)
            3'd0:    s = {2'b00, r0[2*radix-1:radix]} + {2'b00, r1[radix-1:0]}
                         + {{radix{1'b0}}, carry};
            3'd1:    s = {2'b00, r1[2*radix-1:radix]} + {2'b00, r2[radix-1:0]}
                         + {{radix{1'b0}}, carry};
            3'd2:    s = {2'b00, r2[2*radix-1:radix]} + {{radix{1'b0}}, carry};
            default: s = {{radix{1'b0}}, carry};
        endcase
    end

    // NOTE: the wide operand registers are cleared on reset too, so a discarded set
    // leaves nothing behind; all state here is updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            r0        <= '0;
            r1        <= '0;
            r2        <= '0;
            carry     <= '0;
            dig_valid <= 1'b0;
            dig_out   <= '0;
            dig_idx   <= '0;
            dig_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        r0        <= res_0;
                        r1        <= res_1;
                        r2        <= res_2;
                        dig_out   <= res_0[radix-1:0];
                        dig_idx   <= '0;
                        dig_last  <= 1'b0;
                        carry     <= '0;
                        dig_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= EMIT;
                    end
                end
                default: begin
                    if (fire) begin
                        if (dig_last) begin
                            state     <= IDLE;
                            dig_valid <= 1'b0;
                            dig_last  <= 1'b0;
                            dig_idx   <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            dig_out  <= s[radix-1:0];
                            carry    <= s[radix+1:radix];
                            dig_idx  <= dig_idx + 3'd1;
                            dig_last <= (dig_idx == LAST_IDX - 3'd1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
